// File: rtl/key_event_dev.sv
// key_event_dev: synchronised, debounced active-low key inputs feeding an event FIFO,
// with status/control registers and a maskable interrupt on a shared tristate data bus.
module key_event_dev #(
  parameter int              BITS            = 32,
  parameter int              KEY_BITS        = 4,
  parameter logic [BITS-1:0] BASE            = 32'hFFFFF080,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              FIFO_DEPTH      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [KEY_BITS-1:0] INPUT,
  input  logic [BITS-1:0]     ABUS,
  inout  wire  [BITS-1:0]     DBUS,
  input  logic                WE,
  output logic                INTR
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * KEY_BITS;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BITS-1:0] KDATA   = BASE;
  localparam logic [BITS-1:0] KCTRL   = BASE + BITS'(4);
  localparam logic [BITS-1:0] KEVENT  = BASE + BITS'(8);
  localparam logic [BITS-1:0] KCOUNT  = BASE + BITS'(12);

  logic [KEY_BITS-1:0] sync1, sync2, deb, deb_nxt;
  logic [CW-1:0]       cnt     [KEY_BITS];
  logic [CW-1:0]       cnt_nxt [KEY_BITS];

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [KEY_BITS-1:0] chg, keep;
  logic push, pop, full, empty, wr_en, overrun, rd_event, ctrl_we;
  logic ovr, mode, ie;
  logic [BITS-1:0] rdata;
  logic rd_hit;
  logic unused_dbus;

  // Per-key debounce: the counter only runs while sync2 disagrees with the debounced state.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < KEY_BITS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_MAX) deb_nxt[i] = sync2[i];
        else                   cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      for (int i = 0; i < KEY_BITS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= INPUT;
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < KEY_BITS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign chg      = deb ^ deb_nxt;
  assign keep     = mode ? (chg & ~deb_nxt) : chg;
  assign push     = |keep;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_event = (ABUS == KEVENT) && !WE;
  assign pop      = rd_event && !empty;
  // A simultaneous pop frees the slot, so a push at full only overruns without one.
  assign wr_en    = push && (!full || pop);
  assign overrun  = push && full && !pop;
  assign ctrl_we  = WE && (ABUS == KCTRL);

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {~deb_nxt, keep};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovr  <= 1'b0;
      mode <= 1'b0;
      ie   <= 1'b0;
    end else begin
      if (ctrl_we) begin
        mode <= DBUS[2];
        ie   <= DBUS[4];
      end
      if (overrun)                  ovr <= 1'b1;
      else if (ctrl_we && !DBUS[1]) ovr <= 1'b0;
    end
  end

  always_comb begin
    rdata  = '0;
    rd_hit = 1'b0;
    if (!WE) begin
      case (ABUS)
        KDATA: begin
          rd_hit              = 1'b1;
          rdata[KEY_BITS-1:0] = ~deb;
        end
        KCTRL: begin
          rd_hit     = 1'b1;
          rdata[4:0] = {ie, 1'b0, mode, ovr, !empty};
        end
        KEVENT: begin
          rd_hit = 1'b1;
          if (!empty) rdata[EW-1:0] = mem[rd_ptr];
        end
        KCOUNT: begin
          rd_hit      = 1'b1;
          rdata[AW:0] = count;
        end
        default: rd_hit = 1'b0;
      endcase
    end
  end

  assign DBUS        = rd_hit ? rdata : 'z;
  assign INTR        = !empty && ie;
  assign unused_dbus = ^{DBUS[BITS-1:5], DBUS[3], DBUS[0]};

endmodule

// File: tb/tb_key_event_dev.sv
// Bench for key_event_dev: directed register/debounce/FIFO sequences, then random keys
// and bus traffic checked against a history-window reference model.
module tb_key_event_dev;

  localparam logic [31:0] BASE   = 32'hFFFF_F080;
  localparam logic [31:0] KDATA  = BASE;
  localparam logic [31:0] KCTRL  = BASE + 32'd4;
  localparam logic [31:0] KEVENT = BASE + 32'd8;
  localparam logic [31:0] KCOUNT = BASE + 32'd12;
  localparam logic [31:0] IDLE   = 32'h0000_1000;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_in = 4'hF;
  logic [31:0] abus = IDLE;
  logic        we = 1'b0;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_wdat = '0;
  wire  [31:0] dbus;
  logic        intr;

  int checks = 0;
  int errors = 0;

  assign dbus = tb_drv ? tb_wdat : 'z;
  pullup (dbus);

  always #5 clk = ~clk;

  key_event_dev #(
    .BITS(32), .KEY_BITS(4), .BASE(BASE), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RST(rst), .INPUT(key_in), .ABUS(abus), .DBUS(dbus), .WE(we), .INTR(intr)
  );

  // Reference model: a key flips once its last D synchronised samples all disagree with it.
  logic [3:0] hist[$];
  logic [3:0] m_deb;
  logic [7:0] m_q[$];
  logic       m_ovr, m_mode, m_ie;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = {};
      for (int k = 0; k < D + 2; k++) hist.push_front(4'hF);
      m_deb = 4'hF; m_q = {}; m_ovr = 0; m_mode = 0; m_ie = 0;
    end else begin : mdl
      logic [3:0] nd, chg, keep;
      logic       stable, oset;
      hist.push_front(key_in);
      void'(hist.pop_back());
      nd = m_deb;
      for (int i = 0; i < 4; i++) begin
        stable = 1'b1;
        for (int k = 2; k < D + 2; k++) if (hist[k][i] == m_deb[i]) stable = 1'b0;
        if (stable) nd[i] = ~m_deb[i];
      end
      chg  = m_deb ^ nd;
      keep = m_mode ? (chg & ~nd) : chg;
      oset = 1'b0;
      if (abus == KEVENT && !we && m_q.size() > 0) void'(m_q.pop_front());
      if (keep != 0) begin
        if (m_q.size() == DEPTH) oset = 1'b1;
        else m_q.push_back({~nd, keep});
      end
      if (we && abus == KCTRL) begin
        m_mode = dbus[2];
        m_ie   = dbus[4];
        if (!dbus[1]) m_ovr = 1'b0;
      end
      if (oset) m_ovr = 1'b1;
      m_deb = nd;
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == KDATA)                         r[3:0] = ~m_deb;
    else if (a == KCTRL)                    r[4:0] = {m_ie, 1'b0, m_mode, m_ovr, m_q.size() != 0};
    else if (a == KEVENT && m_q.size() > 0) r[7:0] = m_q[0];
    else if (a == KCOUNT)                   r = 32'(m_q.size());
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    abus = a; we = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    d = dbus;
    @(posedge clk);
    #1;
    abus = IDLE;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    abus = a; we = 1'b1; tb_drv = 1'b1; tb_wdat = d;
    @(posedge clk);
    #1;
    we = 1'b0; tb_drv = 1'b0; abus = IDLE;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.dat = d; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) bus_write(vt[i].addr, vt[i].dat);
      else rd_chk($sformatf("%s_vec%0d", tag, i), vt[i].addr, vt[i].exp);
    end
    vt = {};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int op;
    bit is_rd;

    // Reset state and idle bus
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_intr", {31'b0, intr}, 32'h0);
    add(0, KDATA, 0, 32'h0); add(0, KCTRL, 0, 32'h0);
    add(0, KEVENT, 0, 32'h0); add(0, KCOUNT, 0, 32'h0);
    run_vecs("rst");
    @(negedge clk); check("idle_hiz", dbus, 32'hFFFF_FFFF);
    abus = KEVENT + 32'd4 + 32'd8;
    @(negedge clk); check("unrelated_hiz", dbus, 32'hFFFF_FFFF);
    abus = IDLE;
    tick(1);

    // Single press latency and readback
    key_in = 4'b1110;
    tick(5);
    rd_chk("deb_not_yet", KDATA, 32'h0);
    rd_chk("deb_kdata", KDATA, 32'h1);
    rd_chk("p_kcount1", KCOUNT, 32'h1);
    rd_chk("p_kctrl", KCTRL, 32'h1);
    rd_chk("p_kevent", KEVENT, 32'h11);
    rd_chk("p_kcount0", KCOUNT, 32'h0);
    key_in = 4'b1111; tick(8);
    rd_chk("rel_event", KEVENT, 32'h01);

    // Glitch filtering
    key_in = 4'b1011; tick(3); key_in = 4'b1111; tick(10);
    rd_chk("glitch3_count", KCOUNT, 32'h0);
    key_in = 4'b1011; tick(4); key_in = 4'b1111; tick(12);
    rd_chk("glitch4_count", KCOUNT, 32'h2);
    rd_chk("glitch4_press", KEVENT, 32'h44);
    rd_chk("glitch4_rel", KEVENT, 32'h04);

    // Overrun: fifth event dropped
    key_in = 4'b1110; tick(8);
    key_in = 4'b1100; tick(8);
    key_in = 4'b1101; tick(8);
    key_in = 4'b1111; tick(8);
    key_in = 4'b0111; tick(8);
    rd_chk("ovr_count", KCOUNT, 32'h4);
    rd_chk("ovr_kctrl", KCTRL, 32'h3);
    rd_chk("ovr_ev0", KEVENT, 32'h11);
    rd_chk("ovr_ev1", KEVENT, 32'h32);
    rd_chk("ovr_ev2", KEVENT, 32'h21);
    rd_chk("ovr_ev3", KEVENT, 32'h02);
    rd_chk("ovr_empty", KEVENT, 32'h0);
    key_in = 4'b1111; tick(8);
    rd_chk("ovr_after", KEVENT, 32'h08);

    // Control register writes
    add(0, KCTRL, 0, 32'h02);
    add(1, KCTRL, 32'h02, 0); add(0, KCTRL, 0, 32'h02);
    add(1, KCTRL, 32'h10, 0); add(0, KCTRL, 0, 32'h10);
    add(1, KCTRL, 32'h14, 0); add(0, KCTRL, 0, 32'h14);
    add(1, KDATA, 32'hFFFF, 0); add(1, KCOUNT, 32'h7, 0); add(1, KEVENT, 32'h55, 0);
    add(0, KCTRL, 0, 32'h14); add(0, KDATA, 0, 32'h0); add(0, KCOUNT, 0, 32'h0);
    add(1, KCTRL, 32'h00, 0); add(0, KCTRL, 0, 32'h00);
    run_vecs("ctrl");

    // Overrun set and software clear on the same edge
    key_in = 4'b1110; tick(8); key_in = 4'b1111; tick(8);
    key_in = 4'b1110; tick(8); key_in = 4'b1111; tick(8);
    key_in = 4'b1110; tick(5);
    bus_write(KCTRL, 32'h0);
    rd_chk("setclr_kctrl", KCTRL, 32'h3);
    rd_chk("setclr_ev0", KEVENT, 32'h11);
    rd_chk("setclr_ev1", KEVENT, 32'h01);
    rd_chk("setclr_ev2", KEVENT, 32'h11);
    rd_chk("setclr_ev3", KEVENT, 32'h01);
    key_in = 4'b1111; tick(8);
    rd_chk("setclr_rel", KEVENT, 32'h01);
    bus_write(KCTRL, 32'h0);
    rd_chk("setclr_cleared", KCTRL, 32'h0);

    // Press-only mode and interrupt
    bus_write(KCTRL, 32'h14);
    check("irq_idle", {31'b0, intr}, 32'h0);
    key_in = 4'b0111; tick(8);
    check("irq_set", {31'b0, intr}, 32'h1);
    key_in = 4'b1111; tick(8);
    rd_chk("po_count", KCOUNT, 32'h1);
    rd_chk("po_event", KEVENT, 32'h88);
    check("irq_clr", {31'b0, intr}, 32'h0);
    key_in = 4'b1110; tick(8);
    key_in = 4'b1111; tick(8);
    key_in = 4'b1101; tick(8);
    rd_chk("pp_count2", KCOUNT, 32'h2);
    key_in = 4'b1001; tick(5);
    rd_chk("pp_head", KEVENT, 32'h11);
    rd_chk("pp_count", KCOUNT, 32'h2);
    rd_chk("pp_ev1", KEVENT, 32'h22);
    rd_chk("pp_ev2", KEVENT, 32'h64);
    key_in = 4'b1111; tick(8);

    // Reset mid-operation with a key held
    key_in = 4'b0111; tick(8);
    rst = 1'b1; tick(2); rst = 1'b0;
    rd_chk("mr_kdata", KDATA, 32'h0);
    rd_chk("mr_count", KCOUNT, 32'h0);
    rd_chk("mr_kctrl", KCTRL, 32'h0);
    tick(8);
    rd_chk("mr_count1", KCOUNT, 32'h1);
    rd_chk("mr_event", KEVENT, 32'h88);
    key_in = 4'b1111; tick(8);
    rd_chk("mr_rel", KEVENT, 32'h08);

    // Random keys and bus traffic against the model
    for (int c = 0; c < 3000; c++) begin
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 5) == 0) key_in = 4'($urandom);
      we = 1'b0; tb_drv = 1'b0; abus = IDLE; is_rd = 1'b1;
      case (op)
        0:       abus = (c < 1500) ? IDLE : KEVENT;
        1, 2:    abus = KEVENT;
        3, 4:    abus = KCOUNT;
        5, 6:    abus = KCTRL;
        7, 8:    abus = KDATA;
        9: begin
          abus = KCTRL; we = 1'b1; tb_drv = 1'b1; tb_wdat = $urandom; is_rd = 1'b0;
        end
        10: begin
          abus = KEVENT; we = 1'b1; tb_drv = 1'b1; tb_wdat = $urandom; is_rd = 1'b0;
        end
        default: abus = IDLE;
      endcase
      if (c < 1500 && (op == 1 || op == 2)) abus = IDLE;
      @(negedge clk);
      if (is_rd) check("rand_bus", dbus, (abus == IDLE) ? 32'hFFFF_FFFF : model_rd(abus));
      check("rand_intr", {31'b0, intr}, {31'b0, m_ie && m_q.size() != 0});
      @(posedge clk);
      #1;
    end
    we = 1'b0; tb_drv = 1'b0; abus = IDLE;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
